// File: rtl/i2c_txn_arbiter.sv
// rtl/i2c_txn_arbiter.sv - round-robin transaction sequencer in front of a single I2C master
module i2c_txn_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 1024,
  parameter int TW      = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [7*NUM_REQ-1:0] req_addr,
  input  logic [NUM_REQ-1:0]   req_rw,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic                 err,
  output logic [7:0]           rdata,
  output logic                 m_start,
  output logic [7:0]           m_data,
  input  logic                 m_done,
  input  logic                 m_nack,
  input  logic [7:0]           m_rdata
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_WAIT_A = 3'd2,
    S_DATA   = 3'd3,
    S_WAIT_D = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      own_idx;
  logic [6:0]         addr_q;
  logic               rw_q;
  logic [7:0]         wdata_q;
  logic               err_flag;
  logic [TW-1:0]      cnt;

  logic               win_found;
  logic [PW-1:0]      win_idx;
  logic [NUM_REQ-1:0] win_onehot;
  logic [6:0]         win_addr;
  logic               win_rw;
  logic [7:0]         win_wdata;
  int                 cand;

  logic               timeout_hit;
  logic [PW-1:0]      rr_next;

  // The counter is checked one short of TIMEOUT so that exactly TIMEOUT
  // wait cycles elapse before the move to FINISH.
  assign timeout_hit = (cnt == TW'(TIMEOUT - 1));
  assign rr_next     = (own_idx == PW'(NUM_REQ - 1)) ? '0 : own_idx + PW'(1);

  // Round-robin search: first requester at or above rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    win_addr   = '0;
    win_rw     = 1'b0;
    win_wdata  = '0;
    cand       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_found && req[cand]) begin
        win_found           = 1'b1;
        win_idx             = cand[PW-1:0];
        win_onehot[cand]    = 1'b1;
        win_addr            = req_addr[7*cand +: 7];
        win_rw              = req_rw[cand];
        win_wdata           = req_wdata[8*cand +: 8];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decision; m_done only matters in the two wait states.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (win_found) state_nxt = S_ADDR;
      S_ADDR:   state_nxt = S_WAIT_A;
      S_WAIT_A: begin
        if (m_done)           state_nxt = m_nack ? S_FINISH : S_DATA;
        else if (timeout_hit) state_nxt = S_FINISH;
      end
      S_DATA:   state_nxt = S_WAIT_D;
      S_WAIT_D: if (m_done || timeout_hit) state_nxt = S_FINISH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Transaction context, timeout counter, status and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      own_idx  <= '0;
      grant    <= '0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      wdata_q  <= '0;
      err_flag <= 1'b0;
      cnt      <= '0;
      rdata    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            grant    <= win_onehot;
            own_idx  <= win_idx;
            addr_q   <= win_addr;
            rw_q     <= win_rw;
            wdata_q  <= win_wdata;
            err_flag <= 1'b0;
          end
        end
        S_ADDR: cnt <= '0;
        S_WAIT_A: begin
          if (m_done) begin
            if (m_nack) err_flag <= 1'b1;
          end else if (timeout_hit) begin
            err_flag <= 1'b1;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end
        S_DATA: cnt <= '0;
        S_WAIT_D: begin
          if (m_done) begin
            if (rw_q) rdata <= m_rdata;
            err_flag <= m_nack;
          end else if (timeout_hit) begin
            err_flag <= 1'b1;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end
        S_FINISH: begin
          grant  <= '0;
          rr_ptr <= rr_next;
        end
        default: ;
      endcase
    end
  end

  // Master strobes and requester status decoded from the current state.
  always_comb begin
    m_start = 1'b0;
    m_data  = 8'h00;
    done    = '0;
    err     = 1'b0;
    case (state)
      S_ADDR:   begin m_start = 1'b1; m_data = {addr_q, rw_q}; end
      S_WAIT_A: m_data = {addr_q, rw_q};
      S_DATA:   begin m_start = 1'b1; m_data = rw_q ? 8'h00 : wdata_q; end
      S_WAIT_D: m_data = rw_q ? 8'h00 : wdata_q;
      S_FINISH: begin done = grant; err = err_flag; end
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb/tb_i2c_txn_arbiter.sv - self-checking bench for i2c_txn_arbiter
module tb_i2c_txn_arbiter;

  localparam int N  = 3;
  localparam int TO = 16;
  localparam int TWB = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [7*N-1:0] req_addr;
  logic [N-1:0]   req_rw;
  logic [8*N-1:0] req_wdata;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           err;
  logic [7:0]     rdata;
  logic           m_start;
  logic [7:0]     m_data;
  logic           m_done  = 1'b0;
  logic           m_nack  = 1'b0;
  logic [7:0]     m_rdata = 8'h00;

  i2c_txn_arbiter #(.NUM_REQ(N), .TIMEOUT(TO), .TW(TWB)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_wdata(req_wdata), .grant(grant), .done(done), .err(err), .rdata(rdata),
    .m_start(m_start), .m_data(m_data), .m_done(m_done), .m_nack(m_nack),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Master model: answers each m_start after mdl_delay cycles unless muted.
  int         mdl_delay = 3;
  bit         mdl_nack_a = 0, mdl_nack_d = 0, mdl_mute = 0;
  logic [7:0] mdl_rd = 8'h00;
  logic [7:0] started[$];
  bit         pending = 0;
  int         pend_cd = 0;

  always @(negedge clk) begin
    m_done  = 1'b0;
    m_nack  = 1'b0;
    m_rdata = 8'($urandom);
    if (rst) begin
      pending = 0;
    end else begin
      if (pending) begin
        pend_cd--;
        if (pend_cd == 0) begin
          pending = 0;
          m_done  = 1'b1;
          m_nack  = (started.size() == 1) ? mdl_nack_a : mdl_nack_d;
          m_rdata = mdl_rd;
        end
      end
      if (m_start) begin
        started.push_back(m_data);
        if (!mdl_mute) begin
          pending = 1;
          pend_cd = mdl_delay;
        end
      end
    end
  end

  // Reference model state.
  int         ptr = 0;
  logic [7:0] exp_rdata = 8'h00;
  logic [N-1:0] last_grant;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  // Called at a negedge while the DUT is idle and req is nonzero.
  task automatic run_txn(input int delay, input bit na, input bit nd, input bit mute,
                         input bit scramble, input logic [7:0] rd);
    int own, lat, exp_lat;
    logic [6:0] a;
    logic rw;
    logic [7:0] wd;
    bit exp_err;
    own = pick(req, ptr);
    a   = req_addr[7*own +: 7];
    rw  = req_rw[own];
    wd  = req_wdata[8*own +: 8];
    mdl_rd = rd; mdl_delay = delay; mdl_nack_a = na; mdl_nack_d = nd; mdl_mute = mute;
    started.delete();
    @(negedge clk);
    last_grant = grant;
    check("grant", 32'(grant), 32'(1) << own);
    check("m_start_at_grant", 32'(m_start), 1);
    check("m_data_addr", 32'(m_data), 32'({a, rw}));
    if (scramble) begin
      req_addr  = 21'($urandom);
      req_rw    = 3'($urandom);
      req_wdata = 24'($urandom);
      req       = req | 3'($urandom);
    end
    lat = 0;
    while (done == '0 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    exp_lat = mute ? TO + 1 : (na ? delay + 1 : 2 * delay + 2);
    check("latency", lat, exp_lat);
    check("done", 32'(done), 32'(1) << own);
    exp_err = mute | na | nd;
    if (rw && !mute && !na) exp_rdata = rd;
    check("err", 32'(err), 32'(exp_err));
    check("rdata", 32'(rdata), 32'(exp_rdata));
    check("num_starts", started.size(), (mute || na) ? 1 : 2);
    if (started.size() > 0) check("byte0", 32'(started[0]), 32'({a, rw}));
    if (started.size() > 1) check("byte1", 32'(started[1]), rw ? 32'h0 : 32'(wd));
    ptr = (own + 1) % N;
    @(negedge clk);
    check("idle_grant", 32'(grant), 0);
    check("idle_done", 32'(done), 0);
    check("idle_m_start", 32'(m_start), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ptr = 0;
    exp_rdata = 8'h00;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = '0; req_addr = '0; req_rw = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(grant), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_m_start", 32'(m_start), 0);
    check("rst_m_data", 32'(m_data), 0);
    rst = 1'b0;

    // Single write from requester 1.
    req_addr[13:7] = 7'h2A; req_rw[1] = 1'b0; req_wdata[15:8] = 8'hA5;
    req = 3'b010;
    run_txn(3, 0, 0, 0, 0, 8'h00);
    check("t1_byte0", 32'(started[0]), 32'h54);
    check("t1_byte1", 32'(started[1]), 32'hA5);
    req = 3'b000;

    // Read from requester 0.
    req_addr[6:0] = 7'h10; req_rw[0] = 1'b1;
    req = 3'b001;
    run_txn(3, 0, 0, 0, 0, 8'h3C);
    check("t2_byte0", 32'(started[0]), 32'h21);
    check("t2_byte1", 32'(started[1]), 32'h00);
    check("t2_rdata", 32'(rdata), 32'h3C);
    req = 3'b000;

    // Round robin from a fresh pointer.
    do_reset();
    req = 3'b111;
    run_txn(1, 0, 0, 0, 0, 8'h11); check("rr_0", 32'(last_grant), 32'h1);
    run_txn(2, 0, 0, 0, 0, 8'h22); check("rr_1", 32'(last_grant), 32'h2);
    run_txn(1, 0, 0, 0, 0, 8'h33); check("rr_2", 32'(last_grant), 32'h4);
    run_txn(3, 0, 0, 0, 0, 8'h44); check("rr_3", 32'(last_grant), 32'h1);
    req = 3'b000;

    // Address NACK, then timeout.
    req = 3'b100;
    run_txn(2, 1, 0, 0, 0, 8'h55);
    req = 3'b000;
    req = 3'b010;
    run_txn(1, 0, 0, 1, 0, 8'h66);
    req = 3'b000;

    // Reset while in WAIT_D.
    req_addr[6:0] = 7'h33; req_rw[0] = 1'b1;
    req = 3'b001;
    mdl_delay = 4; mdl_nack_a = 0; mdl_nack_d = 0; mdl_mute = 0; mdl_rd = 8'h77;
    started.delete();
    @(negedge clk);
    check("mr_grant", 32'(grant), 32'h1);
    repeat (6) begin
      @(negedge clk);
      check("mr_no_done_pre", 32'(done), 0);
    end
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    check("mr_grant0", 32'(grant), 0);
    check("mr_done0", 32'(done), 0);
    check("mr_err0", 32'(err), 0);
    check("mr_rdata0", 32'(rdata), 0);
    check("mr_m_start0", 32'(m_start), 0);
    check("mr_m_data0", 32'(m_data), 0);
    rst = 1'b0;
    ptr = 0;
    exp_rdata = 8'h00;
    repeat (6) begin
      @(negedge clk);
      check("mr_no_done_post", 32'(done), 0);
    end
    req = 3'b100;
    run_txn(1, 0, 0, 0, 0, 8'h88);
    check("mr_regrant", 32'(last_grant), 32'h4);
    req = 3'b111;
    run_txn(1, 0, 0, 0, 0, 8'h99);
    check("mr_ptr0", 32'(last_grant), 32'h1);
    req = req & ~last_grant;

    // Randomized traffic with late request changes.
    for (int t = 0; t < 30; t++) begin
      if (req == '0) req = 3'($urandom_range(1, 7));
      run_txn($urandom_range(1, 4), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
              0, 1, 8'($urandom));
      req = req & ~last_grant;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_txn_arbiter.md
# i2c_txn_arbiter

Transaction sequencer and round-robin arbiter placed in front of the I2C master. It shares the single master among up to `NUM_REQ` on-chip requesters, one per slave type (memory, FIFO, LIFO). For each granted request it drives the master's `start`/`Data` byte interface for an address phase and one data phase, then returns status and read data to that requester. It also guards every byte phase with a timeout.

## Interface
Parameters:
- `NUM_REQ`, 3: number of requesters, 2..8.
- `TIMEOUT`, 1024: maximum cycles allowed in one byte-wait state.
- `TW`, 11: timeout counter width; requires 2^TW > TIMEOUT.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NUM_REQ  request per requester; held high until that requester's `done` pulse.
- `req_addr`  in  7*NUM_REQ  7-bit slave address per requester; requester i occupies bits [7i+6:7i].
- `req_rw`  in  NUM_REQ  1 = read, 0 = write.
- `req_wdata`  in  8*NUM_REQ  write byte per requester; requester i occupies bits [8i+7:8i].
- `grant`  out  NUM_REQ  one-hot owner of the master; 0 when idle.
- `done`  out  NUM_REQ  one-cycle completion pulse, on the owner's bit only.
- `err`  out  1  valid with `done`; 1 = NACK or timeout.
- `rdata`  out  8  read byte; valid with `done` when the owner's `req_rw` was 1.
- `m_start`  out  1  one-cycle pulse to master `start`.
- `m_data`  out  8  byte to master `Data`; held stable from the `m_start` pulse until `m_done`.
- `m_done`  in  1  master one-cycle pulse; current byte and its ACK phase are complete.
- `m_nack`  in  1  valid with `m_done`; 1 = slave did not acknowledge.
- `m_rdata`  in  8  master `received_data`; valid with `m_done`.

## Operation
- States: IDLE → ADDR → WAIT_A → DATA → WAIT_D → FINISH → IDLE.
- **IDLE:**
  - If `req` is nonzero, select the first set bit at or after `rr_ptr`, searching upward and wrapping at `NUM_REQ`.
  - Register the winner into `grant`.
  - Latch the winner's addr, rw and wdata into internal registers.
  - Go to ADDR.
- **ADDR:**
  - Pulse `m_start`.
  - Drive `m_data = {addr, rw}`.
  - Clear the timeout counter.
  - Go to WAIT_A.
- **WAIT_A:**
  - Increment the counter each cycle.
  - On `m_done` with `m_nack`=1: set the error flag and go to FINISH.
  - On `m_done` with `m_nack`=0: go to DATA.
  - When the counter reaches `TIMEOUT` without `m_done`: set the error flag and go to FINISH.
- **DATA:**
  - Pulse `m_start`.
  - Drive `m_data` = latched wdata on a write, or 0x00 on a read.
  - Clear the counter.
  - Go to WAIT_D.
- **WAIT_D:**
  - On `m_done`: capture `m_rdata` into `rdata` if reading, set the error flag from `m_nack`, and go to FINISH.
  - Timeout is handled as in WAIT_A.
- **FINISH:**
  - `done[owner]` = 1 for exactly one cycle; `err` = error flag.
  - Clear `grant`.
  - Set `rr_ptr` = (owner + 1) mod `NUM_REQ`.
  - Go to IDLE.
- Latched addr, rw and wdata are fixed for the whole transaction. Changing `req_*` or dropping `req` after grant has no effect, and the transaction always completes.
- `m_done` outside WAIT_A or WAIT_D is ignored.
- `rdata` holds its last captured value until the next read capture. It is not updated on writes or on timeouts.

## Timing
- Reset values: state IDLE, `rr_ptr` = 0, and every output 0 (`grant`, `done`, `err`, `rdata`, `m_start`, `m_data`).
- Reset mid-transaction aborts on that edge:
  - No `done` pulse is issued.
  - `m_start` is low from the next cycle onward.
  - `rst` overrides every input in the same cycle.
- Latency:
  - `req` seen in IDLE at cycle N → `grant` at N+1 (state ADDR), with `m_start` pulsing in that same cycle.
  - `m_done` at cycle M in WAIT_A → data-phase `m_start` at M+1.
  - `m_done` at cycle K in WAIT_D → `done` at K+1.
  - The next grant is decided in the IDLE cycle at K+2; it is visible at K+3.
- Minimum transaction, with `m_done` arriving on the first wait cycle: 6 cycles from IDLE to the return to IDLE.
- Timeout: `TIMEOUT` cycles in a wait state with no `m_done` → FINISH on the following cycle.
- Arbitration fairness: a continuously requesting requester is granted within `NUM_REQ` transactions.
- Simultaneous requests are served in pointer order.
- A `req` rising during a transaction waits for IDLE; it does not preempt.

## Test plan
- Single write: reset; requester 1 with addr 0x2A, rw 0, wdata 0xA5; the bench's master model returns `m_done` 3 cycles after each `m_start` → `m_data` is 0x54 then 0xA5; `done` = 3'b010 with `err` = 0.
- Read: requester 0 with addr 0x10, rw 1; model returns `m_rdata` = 0x3C → `m_data` is 0x21 then 0x00; `done[0]` with `rdata` = 0x3C and `err` = 0.
- Round robin: `req` = 3'b111 held high, all transactions complete → grant order 001, 010, 100, 001; `rr_ptr` wraps.
- NACK: `m_nack` = 1 on the address `m_done` → no second `m_start`; `done` one cycle later with `err` = 1.
- Timeout: `TIMEOUT` = 16 and `m_done` never arrives → `done` with `err` = 1 on the 17th cycle after entering WAIT_A; `grant` then clears.
- Reset mid-transaction: assert `rst` in WAIT_D → every output is 0 on the next cycle, no `done` pulse, and a new `req[2]` is granted normally after reset with `rr_ptr` = 0.
